// File: rtl/reg_word_assembler_pkg.sv
// Shared types and sizing helpers for the beat-to-word assembler.
// Beat count and counter width derive from DATA_W/BUS_W only.
package reg_word_assembler_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_COMMIT
  } state_t;

  function automatic int rwa_nbeats(input int dw, input int bw);
    return (dw + bw - 1) / bw;
  endfunction

  function automatic int rwa_cnt_w(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/reg_word_assembler.sv
// Assembles LSB-first bus beats into one wide word and
// presents it with a single-cycle write strobe.
module reg_word_assembler
  import reg_word_assembler_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int BUS_W  = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [BUS_W-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clr,
  output logic [DATA_W-1:0] dout,
  output logic              wen,
  output logic              busy
);

  localparam int NB = rwa_nbeats(DATA_W, BUS_W);
  localparam int CW = rwa_cnt_w(NB);
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  state_t            r_state;
  state_t            w_state_nx;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nx;
  logic [DATA_W-1:0] r_shadow;
  logic [DATA_W-1:0] w_shadow_nx;
  logic [DATA_W-1:0] w_beat;

  // Bits of the last beat beyond DATA_W fall off the shift.
  assign w_beat = DATA_W'(in_data) << (int'(r_cnt) * BUS_W);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_cnt    <= w_cnt_nx;
      r_shadow <= w_shadow_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_shadow_nx = r_shadow;
    in_ready    = 1'b0;
    wen         = 1'b0;
    unique case (r_state)
      S_IDLE, S_FILL: begin
        in_ready = !clr;
        if (clr) begin
          w_state_nx  = S_IDLE;
          w_cnt_nx    = '0;
          w_shadow_nx = '0;
        end else if (in_valid) begin
          w_shadow_nx = r_shadow | w_beat;
          if (r_cnt == LAST) begin
            w_state_nx = S_COMMIT;
            w_cnt_nx   = '0;
          end else begin
            w_state_nx = S_FILL;
            w_cnt_nx   = r_cnt + 1'b1;
          end
        end
      end
      S_COMMIT: begin
        // Shadow clears here so IDLE always starts from zero.
        wen         = 1'b1;
        w_state_nx  = S_IDLE;
        w_cnt_nx    = '0;
        w_shadow_nx = '0;
      end
      default: begin
        w_state_nx  = S_IDLE;
        w_cnt_nx    = '0;
        w_shadow_nx = '0;
      end
    endcase
  end

  assign dout = r_shadow;
  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_reg_word_assembler.sv
// Directed-vector bench for reg_word_assembler in a
// 20/8 configuration and a single-beat 8/8 configuration.
module tb_reg_word_assembler;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        clr;
  logic [19:0] dout;
  logic        wen;
  logic        busy;

  logic [7:0]  in_data8;
  logic        in_valid8;
  logic        in_ready8;
  logic        clr8;
  logic [7:0]  dout8;
  logic        wen8;
  logic        busy8;

  int n_tests = 0;
  int n_fail  = 0;
  int wen_cnt = 0;
  int wen8_cnt = 0;

  always #5 clk = ~clk;

  reg_word_assembler #(.DATA_W(20), .BUS_W(8)) u_dut (
    .clk(clk), .arst_n(arst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .clr(clr), .dout(dout), .wen(wen), .busy(busy)
  );

  reg_word_assembler #(.DATA_W(8), .BUS_W(8)) u_dut8 (
    .clk(clk), .arst_n(arst_n),
    .in_data(in_data8), .in_valid(in_valid8), .in_ready(in_ready8),
    .clr(clr8), .dout(dout8), .wen(wen8), .busy(busy8)
  );

  always @(negedge clk) begin
    if (wen === 1'b1) wen_cnt++;
    if (wen8 === 1'b1) wen8_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    #2;
    n_tests++;
    if (dout !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_dout got %h want 00000", dout);
    end
    n_tests++;
    if ({wen, busy, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 001", {wen, busy, in_ready});
    end
    tick();
    arst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = wen_cnt;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_idle got %b want 1", in_ready);
    end
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_data = 8'h3C;
    tick();
    n_tests++;
    if ({wen, busy, in_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL b2b_fill_flags got %b want 011", {wen, busy, in_ready});
    end
    in_data = 8'hF7;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (dout !== 20'h73CA5) begin
      n_fail++;
      $display("FAIL b2b_dout got %h want 73ca5", dout);
    end
    n_tests++;
    if ({wen, busy, in_ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL b2b_commit_flags got %b want 110", {wen, busy, in_ready});
    end
    tick();
    n_tests++;
    if ({wen, busy, dout} !== {2'b00, 20'h0}) begin
      n_fail++;
      $display("FAIL b2b_after got wen=%b busy=%b dout=%h want 0 0 00000",
               wen, busy, dout);
    end
    n_tests++;
    if (wen_cnt - w0 !== 1) begin
      n_fail++;
      $display("FAIL b2b_pulses got %0d want 1", wen_cnt - w0);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] beats [3];
    int w0;
    int bad;
    beats[0] = 8'hA5;
    beats[1] = 8'h3C;
    beats[2] = 8'hF7;
    w0  = wen_cnt;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      send(beats[i]);
      if (i < 2) begin
        for (int g = 0; g < 2; g++) begin
          if (busy !== 1'b1 || wen !== 1'b0) bad++;
          tick();
        end
        if (busy !== 1'b1 || wen !== 1'b0) bad++;
      end
    end
    n_tests++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL gaps_busy bad_cycles=%0d want 0", bad);
    end
    n_tests++;
    if ({wen, busy, dout} !== {2'b11, 20'h73CA5}) begin
      n_fail++;
      $display("FAIL gaps_commit got wen=%b busy=%b dout=%h want 1 1 73ca5",
               wen, busy, dout);
    end
    tick();
    n_tests++;
    if (busy !== 1'b0 || wen_cnt - w0 !== 1) begin
      n_fail++;
      $display("FAIL gaps_end got busy=%b pulses=%0d want 0 1",
               busy, wen_cnt - w0);
    end
  endtask

  task automatic test_clr_fill();
    int w0;
    w0 = wen_cnt;
    send(8'h11);
    send(8'h22);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_ready got %b want 0", in_ready);
    end
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    n_tests++;
    if ({wen, busy, dout} !== {2'b00, 20'h0}) begin
      n_fail++;
      $display("FAIL clr_state got wen=%b busy=%b dout=%h want 0 0 00000",
               wen, busy, dout);
    end
    send(8'h01);
    send(8'h02);
    send(8'h03);
    n_tests++;
    if ({wen, dout} !== {1'b1, 20'h30201}) begin
      n_fail++;
      $display("FAIL clr_next_word got wen=%b dout=%h want 1 30201", wen, dout);
    end
    tick();
    n_tests++;
    if (wen_cnt - w0 !== 1) begin
      n_fail++;
      $display("FAIL clr_pulses got %0d want 1", wen_cnt - w0);
    end
  endtask

  task automatic test_clr_commit();
    int w0;
    w0 = wen_cnt;
    send(8'h45);
    send(8'h23);
    send(8'h01);
    clr = 1'b1;
    #1;
    n_tests++;
    if ({wen, in_ready, dout} !== {2'b10, 20'h12345}) begin
      n_fail++;
      $display("FAIL clrc_commit got wen=%b rdy=%b dout=%h want 1 0 12345",
               wen, in_ready, dout);
    end
    tick();
    clr = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || wen_cnt - w0 !== 1) begin
      n_fail++;
      $display("FAIL clrc_end got busy=%b pulses=%0d want 0 1",
               busy, wen_cnt - w0);
    end
  endtask

  task automatic test_async_reset();
    int w0;
    w0 = wen_cnt;
    send(8'hAA);
    send(8'hBB);
    arst_n = 1'b0;
    #1;
    n_tests++;
    if ({wen, busy, dout} !== {2'b00, 20'h0}) begin
      n_fail++;
      $display("FAIL arst_state got wen=%b busy=%b dout=%h want 0 0 00000",
               wen, busy, dout);
    end
    tick();
    arst_n = 1'b1;
    send(8'h0F);
    send(8'hF0);
    send(8'h05);
    n_tests++;
    if ({wen, dout} !== {1'b1, 20'h5F00F}) begin
      n_fail++;
      $display("FAIL arst_word got wen=%b dout=%h want 1 5f00f", wen, dout);
    end
    tick();
    n_tests++;
    if (wen_cnt - w0 !== 1) begin
      n_fail++;
      $display("FAIL arst_pulses got %0d want 1", wen_cnt - w0);
    end
  endtask

  task automatic test_single_beat();
    int w0;
    w0 = wen8_cnt;
    in_valid8 = 1'b1;
    in_data8  = 8'h5A;
    tick();
    in_data8 = 8'hC3;
    n_tests++;
    if ({wen8, in_ready8, busy8, dout8} !== {3'b101, 8'h5A}) begin
      n_fail++;
      $display("FAIL sb_commit got wen=%b rdy=%b busy=%b dout=%h want 1 0 1 5a",
               wen8, in_ready8, busy8, dout8);
    end
    tick();
    n_tests++;
    if ({wen8, in_ready8, dout8} !== {2'b01, 8'h00}) begin
      n_fail++;
      $display("FAIL sb_idle got wen=%b rdy=%b dout=%h want 0 1 00",
               wen8, in_ready8, dout8);
    end
    tick();
    n_tests++;
    if ({wen8, dout8} !== {1'b1, 8'hC3}) begin
      n_fail++;
      $display("FAIL sb_second got wen=%b dout=%h want 1 c3", wen8, dout8);
    end
    tick();
    tick();
    tick();
    in_valid8 = 1'b0;
    tick();
    n_tests++;
    if (wen8_cnt - w0 !== 3) begin
      n_fail++;
      $display("FAIL sb_rate got %0d pulses want 3", wen8_cnt - w0);
    end
  endtask

  initial begin
    in_data   = '0;
    in_valid  = 1'b0;
    clr       = 1'b0;
    in_data8  = '0;
    in_valid8 = 1'b0;
    clr8      = 1'b0;
    test_reset();
    test_back_to_back();
    test_gaps();
    test_clr_fill();
    test_clr_commit();
    test_async_reset();
    test_single_beat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
